// File: rtl/riscv_data_buf_pkg.sv
// Shared types for the LSU data request buffer: request payload, issue FSM
// states and the "plain access" atomic opcode.
package riscv_data_buf_pkg;

   localparam logic [5:0] ATOP_NONE = 6'd0;

   typedef struct packed {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [5:0]  atop;
   } data_req_t;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      ATOP_DRAIN
   } issue_state_e;

   function automatic logic is_atomic(input data_req_t r);
      return r.atop != ATOP_NONE;
   endfunction

endpackage

// File: rtl/riscv_data_req_fifo.sv
// DEPTH-entry request FIFO. Exposes the head and the entry behind it so the
// issue logic can decide back-to-back issue in the same cycle it pops.
module riscv_data_req_fifo
   import riscv_data_buf_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic      clk_i,
   input  logic      rst_i,
   input  logic      push_i,
   input  data_req_t data_i,
   input  logic      pop_i,
   output data_req_t head_o,
   output data_req_t second_o,
   output logic      full_o,
   output logic      empty_o,
   output logic      one_o
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

   data_req_t     mem_q [DEPTH];
   logic [AW-1:0] wr_idx_q, rd_idx_q;
   logic          wr_wrap_q, rd_wrap_q;

   // Indices wrap modulo DEPTH (not a power of two in general); the wrap
   // bit toggles on each wrap and tells full from empty.
   function automatic logic [AW-1:0] idx_inc(input logic [AW-1:0] idx);
      return (idx == LAST_IDX) ? '0 : idx + 1'b1;
   endfunction

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_idx_q  <= '0;
         rd_idx_q  <= '0;
         wr_wrap_q <= 1'b0;
         rd_wrap_q <= 1'b0;
      end else begin
         if (push_i) begin
            wr_idx_q <= idx_inc(wr_idx_q);
            if (wr_idx_q == LAST_IDX) wr_wrap_q <= ~wr_wrap_q;
         end
         if (pop_i) begin
            rd_idx_q <= idx_inc(rd_idx_q);
            if (rd_idx_q == LAST_IDX) rd_wrap_q <= ~rd_wrap_q;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i) mem_q[wr_idx_q] <= data_i;
   end

   assign empty_o  = (wr_idx_q == rd_idx_q) && (wr_wrap_q == rd_wrap_q);
   assign full_o   = (wr_idx_q == rd_idx_q) && (wr_wrap_q != rd_wrap_q);
   assign one_o    = !empty_o && (idx_inc(rd_idx_q) == wr_idx_q);
   assign head_o   = mem_q[rd_idx_q];
   assign second_o = mem_q[idx_inc(rd_idx_q)];

endmodule

// File: rtl/riscv_data_req_buffer.sv
// LSU-to-memory request buffer: queues LSU requests, issues them in order on
// an OBI-style port, fences atomics and passes responses straight through.
module riscv_data_req_buffer
   import riscv_data_buf_pkg::*;
#(
   parameter int unsigned DEPTH           = 2,
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        lsu_req_i,
   output logic        lsu_gnt_o,
   input  logic [31:0] lsu_addr_i,
   input  logic        lsu_we_i,
   input  logic [3:0]  lsu_be_i,
   input  logic [31:0] lsu_wdata_i,
   input  logic [5:0]  lsu_atop_i,
   output logic        lsu_rvalid_o,
   output logic [31:0] lsu_rdata_o,
   output logic        lsu_err_o,
   output logic        mem_req_o,
   input  logic        mem_gnt_i,
   output logic [31:0] mem_addr_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_wdata_o,
   output logic [5:0]  mem_atop_o,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   input  logic        mem_err_i,
   output logic        busy_o,
   output logic        protocol_err_o
);

   localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

   issue_state_e  state_q, state_d;
   logic [CW-1:0] acc_cnt_q, acc_cnt_d;
   logic [CW-1:0] iss_cnt_q, iss_cnt_d;
   logic          atop_inflight_q, atop_inflight_d;
   logic          protocol_err_q, protocol_err_d;

   data_req_t lsu_req_s, head_s, second_s, cand_s, mem_req_s;
   logic      fifo_full, fifo_empty, fifo_one;
   logic      push, pop, mem_hs, resp_valid, cand_valid;

   assign lsu_req_s = '{addr: lsu_addr_i, we: lsu_we_i, be: lsu_be_i,
                        wdata: lsu_wdata_i, atop: lsu_atop_i};

   assign lsu_gnt_o  = lsu_req_i && !fifo_full && (acc_cnt_q < CW'(MAX_OUTSTANDING));
   assign push       = lsu_gnt_o;
   assign mem_hs     = (state_q == REQ) && mem_gnt_i;
   assign pop        = mem_hs;
   assign resp_valid = mem_rvalid_i && (iss_cnt_q != '0);

   riscv_data_req_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .push_i   (push),
      .data_i   (lsu_req_s),
      .pop_i    (pop),
      .head_o   (head_s),
      .second_o (second_s),
      .full_o   (fifo_full),
      .empty_o  (fifo_empty),
      .one_o    (fifo_one)
   );

   // Entry that will be at the FIFO head next cycle, including a request
   // being pushed now; this is what gives one-cycle LSU-to-memory latency.
   always_comb begin
      cand_valid = !fifo_empty || push;
      cand_s     = fifo_empty ? lsu_req_s : head_s;
      if (mem_hs) begin
         cand_valid = !fifo_one || push;
         cand_s     = fifo_one ? lsu_req_s : second_s;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q         <= IDLE;
         acc_cnt_q       <= '0;
         iss_cnt_q       <= '0;
         atop_inflight_q <= 1'b0;
         protocol_err_q  <= 1'b0;
      end else begin
         state_q         <= state_d;
         acc_cnt_q       <= acc_cnt_d;
         iss_cnt_q       <= iss_cnt_d;
         atop_inflight_q <= atop_inflight_d;
         protocol_err_q  <= protocol_err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (cand_valid) begin
               if (is_atomic(cand_s)) state_d = (iss_cnt_q != '0) ? ATOP_DRAIN : REQ;
               else if (!atop_inflight_q) state_d = REQ;
            end
         end
         REQ: begin
            if (mem_gnt_i) begin
               if (!cand_valid) state_d = IDLE;
               else if (is_atomic(cand_s)) state_d = ATOP_DRAIN;
               else if (is_atomic(head_s) || atop_inflight_q) state_d = IDLE;
               else state_d = REQ;
            end
         end
         ATOP_DRAIN: begin
            if (iss_cnt_q == '0) state_d = REQ;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      acc_cnt_d = acc_cnt_q;
      if (push && !resp_valid) acc_cnt_d = acc_cnt_q + 1'b1;
      else if (!push && resp_valid) acc_cnt_d = acc_cnt_q - 1'b1;

      iss_cnt_d = iss_cnt_q;
      if (mem_hs && !resp_valid) iss_cnt_d = iss_cnt_q + 1'b1;
      else if (!mem_hs && resp_valid) iss_cnt_d = iss_cnt_q - 1'b1;

      // An atomic is only issued with nothing in flight, so the next
      // response after its grant is its own.
      atop_inflight_d = atop_inflight_q;
      if (mem_hs && is_atomic(head_s)) atop_inflight_d = 1'b1;
      else if (resp_valid) atop_inflight_d = 1'b0;

      protocol_err_d = protocol_err_q || (mem_rvalid_i && (iss_cnt_q == '0));
   end

   always_comb begin
      mem_req_o = (state_q == REQ);
      mem_req_s = mem_req_o ? head_s : '0;
   end

   assign mem_addr_o     = mem_req_s.addr;
   assign mem_we_o       = mem_req_s.we;
   assign mem_be_o       = mem_req_s.be;
   assign mem_wdata_o    = mem_req_s.wdata;
   assign mem_atop_o     = mem_req_s.atop;

   assign lsu_rvalid_o   = resp_valid;
   assign lsu_rdata_o    = mem_rdata_i;
   assign lsu_err_o      = mem_err_i && resp_valid;
   assign busy_o         = (acc_cnt_q != '0) || lsu_req_i;
   assign protocol_err_o = protocol_err_q;

endmodule

// File: tb/tb_riscv_data_req_buffer.sv
// Bench for riscv_data_req_buffer: vector table, directed corner sequences and
// a randomized run against a queue-based transaction model.
module tb_riscv_data_req_buffer;
   import riscv_data_buf_pkg::*;

   localparam int DEPTH = 2;
   localparam int MAXO  = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_i, lsu_req_i, lsu_gnt_o, lsu_we_i, lsu_rvalid_o, lsu_err_o;
   logic [31:0] lsu_addr_i, lsu_wdata_i, lsu_rdata_o;
   logic [3:0]  lsu_be_i, mem_be_o;
   logic [5:0]  lsu_atop_i, mem_atop_o;
   logic        mem_req_o, mem_gnt_i, mem_we_o, mem_rvalid_i, mem_err_i;
   logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
   logic        busy_o, protocol_err_o;

   riscv_data_req_buffer #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .lsu_req_i(lsu_req_i), .lsu_gnt_o(lsu_gnt_o), .lsu_addr_i(lsu_addr_i),
      .lsu_we_i(lsu_we_i), .lsu_be_i(lsu_be_i), .lsu_wdata_i(lsu_wdata_i),
      .lsu_atop_i(lsu_atop_i), .lsu_rvalid_o(lsu_rvalid_o), .lsu_rdata_o(lsu_rdata_o),
      .lsu_err_o(lsu_err_o), .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i),
      .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
      .mem_wdata_o(mem_wdata_o), .mem_atop_o(mem_atop_o), .mem_rvalid_i(mem_rvalid_i),
      .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i), .busy_o(busy_o),
      .protocol_err_o(protocol_err_o)
   );

   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual=0x%08h required=0x%08h @%0t", name, act, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_lsu(input logic req, input data_req_t r);
      lsu_req_i   = req;
      lsu_addr_i  = r.addr;
      lsu_we_i    = r.we;
      lsu_be_i    = r.be;
      lsu_wdata_i = r.wdata;
      lsu_atop_i  = r.atop;
   endtask

   task automatic idle_inputs();
      drive_lsu(1'b0, '0);
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
      mem_err_i    = 1'b0;
   endtask

   // Transaction model: lq = waiting at the LSU, aq = accepted but not yet
   // issued, gq = issued and awaiting response (in-order memory).
   typedef struct {
      data_req_t req;
      int        ready;
      logic      err;
   } iss_t;

   data_req_t   lq[$];
   data_req_t   aq[$];
   iss_t        gq[$];
   logic [31:0] log_acc_addr[$], log_iss_addr[$], log_rsp_addr[$];
   int          log_acc_cyc[$], log_iss_cyc[$], log_rsp_cyc[$];
   logic [5:0]  log_iss_atop[$];

   function automatic logic [31:0] rdata_of(input logic [31:0] addr);
      return addr ^ 32'h5A5A_0F0F;
   endfunction

   task automatic do_reset();
      rst_i = 1'b1;
      idle_inputs();
      tick();
      tick();
      rst_i = 1'b0;
      lq.delete(); aq.delete(); gq.delete();
   endtask

   task automatic run_engine(input int max_cyc, input int gnt_from, input int gnt_pct,
                             input int lat_min, input int lat_max, input int err_pct);
      bit        prev_stall = 1'b0;
      bit        done = 1'b0;
      data_req_t prev_req = '0;
      logic      exp_gnt;
      bit        has_atomic;
      log_acc_addr.delete(); log_acc_cyc.delete();
      log_iss_addr.delete(); log_iss_cyc.delete(); log_iss_atop.delete();
      log_rsp_addr.delete(); log_rsp_cyc.delete();
      for (int cyc = 0; cyc < max_cyc && !done; cyc++) begin
         if (lq.size() != 0) drive_lsu(1'b1, lq[0]);
         else drive_lsu(1'b0, '0);
         mem_gnt_i = (cyc >= gnt_from) && ($urandom_range(0, 99) < gnt_pct);
         if (gq.size() != 0 && cyc >= gq[0].ready) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = rdata_of(gq[0].req.addr);
            mem_err_i    = gq[0].err;
         end else begin
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = '0;
            mem_err_i    = 1'b0;
         end
         @(negedge clk);
         exp_gnt = lsu_req_i && (aq.size() < DEPTH) && (aq.size() + gq.size() < MAXO);
         chk("lsu_gnt", lsu_gnt_o, exp_gnt);
         chk("busy", busy_o, (aq.size() + gq.size() != 0) || lsu_req_i);
         chk("lsu_rvalid", lsu_rvalid_o, mem_rvalid_i);
         if (aq.size() == 0) chk("mem_req_empty", mem_req_o, 1'b0);
         if (prev_stall) begin
            chk("stable_req", mem_req_o, 1'b1);
            chk("stable_addr", mem_addr_o, prev_req.addr);
            chk("stable_payload", {mem_we_o, mem_be_o, mem_atop_o, mem_wdata_o},
                {prev_req.we, prev_req.be, prev_req.atop, prev_req.wdata});
         end
         prev_stall = mem_req_o && !mem_gnt_i;
         prev_req   = '{addr: mem_addr_o, we: mem_we_o, be: mem_be_o, wdata: mem_wdata_o, atop: mem_atop_o};
         if (mem_req_o && mem_gnt_i && aq.size() != 0) begin
            chk("iss_addr", mem_addr_o, aq[0].addr);
            chk("iss_we_be", {mem_we_o, mem_be_o}, {aq[0].we, aq[0].be});
            chk("iss_wdata", mem_wdata_o, aq[0].wdata);
            chk("iss_atop", mem_atop_o, aq[0].atop);
            has_atomic = 1'b0;
            foreach (gq[i]) if (gq[i].req.atop != ATOP_NONE) has_atomic = 1'b1;
            if (aq[0].atop != ATOP_NONE) chk("atomic_fence_before", gq.size(), 0);
            else chk("atomic_fence_after", has_atomic, 1'b0);
         end
         if (mem_rvalid_i) begin
            chk("lsu_rdata", lsu_rdata_o, rdata_of(gq[0].req.addr));
            chk("lsu_err", lsu_err_o, gq[0].err);
            $display("txn resp addr=0x%08h we=%0b atop=0x%02h rdata=0x%08h err=%0b cyc=%0d",
                     gq[0].req.addr, gq[0].req.we, gq[0].req.atop, lsu_rdata_o, lsu_err_o, cyc);
            log_rsp_addr.push_back(gq[0].req.addr);
            log_rsp_cyc.push_back(cyc);
            void'(gq.pop_front());
         end
         if (mem_req_o && mem_gnt_i && aq.size() != 0) begin
            log_iss_addr.push_back(aq[0].addr);
            log_iss_cyc.push_back(cyc);
            log_iss_atop.push_back(mem_atop_o);
            gq.push_back('{req: aq[0], ready: cyc + int'($urandom_range(lat_min, lat_max)),
                           err: ($urandom_range(0, 99) < err_pct)});
            void'(aq.pop_front());
         end
         if (lsu_req_i && lsu_gnt_o && lq.size() != 0) begin
            log_acc_addr.push_back(lq[0].addr);
            log_acc_cyc.push_back(cyc);
            aq.push_back(lq.pop_front());
         end
         tick();
         done = (lq.size() == 0 && aq.size() == 0 && gq.size() == 0);
      end
      idle_inputs();
      chk("engine_done", done, 1'b1);
   endtask

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [5:0]  atop;
      logic [31:0] rdata;
      logic        err;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs[5];

   initial begin
      vecs[0] = '{32'h0000_1000, 1'b0, 4'hF, 32'h0,         6'h00, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0};
      vecs[1] = '{32'h0000_2004, 1'b1, 4'h3, 32'h1234_5678, 6'h00, 32'h0,         1'b0, 32'h0,         1'b0};
      vecs[2] = '{32'h0000_3000, 1'b0, 4'hF, 32'h0,         6'h00, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D, 1'b1};
      vecs[3] = '{32'h0000_3004, 1'b0, 4'hC, 32'h0,         6'h00, 32'h0BAD_C0DE, 1'b0, 32'h0BAD_C0DE, 1'b0};
      vecs[4] = '{32'h0000_0040, 1'b1, 4'hF, 32'h0000_0005, 6'h21, 32'h0000_0077, 1'b0, 32'h0000_0077, 1'b0};

      rst_i = 1'b1;
      idle_inputs();
      #1;
      do_reset();

      // reset state
      @(negedge clk);
      chk("rst_mem_req", mem_req_o, 1'b0);
      chk("rst_lsu_gnt", lsu_gnt_o, 1'b0);
      chk("rst_lsu_rvalid", lsu_rvalid_o, 1'b0);
      chk("rst_busy", busy_o, 1'b0);
      chk("rst_protocol_err", protocol_err_o, 1'b0);
      chk("rst_mem_payload", {mem_addr_o ^ mem_wdata_o, 3'b0, mem_we_o, mem_be_o, mem_atop_o}, 32'h0);
      chk("rst_lsu_rdata", lsu_rdata_o, 32'h0);
      tick();

      // single transactions from the vector table
      for (int i = 0; i < 5; i++) begin
         drive_lsu(1'b1, '{addr: vecs[i].addr, we: vecs[i].we, be: vecs[i].be,
                           wdata: vecs[i].wdata, atop: vecs[i].atop});
         @(negedge clk);
         chk("vec_gnt", lsu_gnt_o, 1'b1);
         chk("vec_no_fallthrough", mem_req_o, 1'b0);
         chk("vec_busy_req", busy_o, 1'b1);
         tick();
         drive_lsu(1'b0, '0);
         mem_gnt_i = 1'b1;
         @(negedge clk);
         chk("vec_mem_req", mem_req_o, 1'b1);
         chk("vec_mem_addr", mem_addr_o, vecs[i].addr);
         chk("vec_mem_we_be", {mem_we_o, mem_be_o}, {vecs[i].we, vecs[i].be});
         chk("vec_mem_wdata", mem_wdata_o, vecs[i].wdata);
         chk("vec_mem_atop", mem_atop_o, vecs[i].atop);
         tick();
         mem_gnt_i = 1'b0;
         @(negedge clk);
         chk("vec_req_drop", mem_req_o, 1'b0);
         chk("vec_busy_wait", busy_o, 1'b1);
         chk("vec_no_early_rvalid", lsu_rvalid_o, 1'b0);
         tick();
         mem_rvalid_i = 1'b1;
         mem_rdata_i  = vecs[i].rdata;
         mem_err_i    = vecs[i].err;
         @(negedge clk);
         chk("vec_rvalid", lsu_rvalid_o, 1'b1);
         chk("vec_rdata", lsu_rdata_o, vecs[i].exp_rdata);
         chk("vec_err", lsu_err_o, vecs[i].exp_err);
         $display("txn vec %0d addr=0x%08h rdata=0x%08h err=%0b", i, vecs[i].addr, lsu_rdata_o, lsu_err_o);
         tick();
         idle_inputs();
         @(negedge clk);
         chk("vec_busy_done", busy_o, 1'b0);
         chk("vec_rvalid_done", lsu_rvalid_o, 1'b0);
         tick();
      end

      // memory stall with a full FIFO
      do_reset();
      lq.push_back('{addr: 32'h100, we: 1'b0, be: 4'hF, wdata: 32'h0, atop: 6'h0});
      lq.push_back('{addr: 32'h104, we: 1'b0, be: 4'hF, wdata: 32'h0, atop: 6'h0});
      lq.push_back('{addr: 32'h108, we: 1'b0, be: 4'hF, wdata: 32'h0, atop: 6'h0});
      run_engine(60, 6, 100, 1, 1, 0);
      chk("stall_log_size", log_iss_addr.size() * 16 + log_acc_cyc.size(), 3 * 16 + 3);
      if (log_iss_addr.size() == 3 && log_acc_cyc.size() == 3) begin
         chk("stall_acc0_cyc", log_acc_cyc[0], 0);
         chk("stall_acc1_cyc", log_acc_cyc[1], 1);
         chk("stall_acc2_withheld", log_acc_cyc[2] > 6, 1'b1);
         chk("stall_iss0_cyc", log_iss_cyc[0], 6);
         chk("stall_order0", log_iss_addr[0], 32'h100);
         chk("stall_order1", log_iss_addr[1], 32'h104);
         chk("stall_order2", log_iss_addr[2], 32'h108);
      end

      // atomic fencing in both directions
      do_reset();
      lq.push_back('{addr: 32'h200, we: 1'b1, be: 4'hF, wdata: 32'hA0A0_0001, atop: 6'h00});
      lq.push_back('{addr: 32'h300, we: 1'b1, be: 4'hF, wdata: 32'h0000_0003, atop: 6'h21});
      lq.push_back('{addr: 32'h304, we: 1'b0, be: 4'hF, wdata: 32'h0,         atop: 6'h00});
      run_engine(80, 0, 100, 4, 4, 0);
      chk("fence_log_size", log_iss_addr.size() * 16 + log_rsp_addr.size(), 3 * 16 + 3);
      if (log_iss_addr.size() == 3 && log_rsp_addr.size() == 3) begin
         chk("fence_order0", log_iss_addr[0], 32'h200);
         chk("fence_order1", log_iss_addr[1], 32'h300);
         chk("fence_order2", log_iss_addr[2], 32'h304);
         chk("fence_atop", log_iss_atop[1], 6'h21);
         chk("fence_atomic_after_store", log_iss_cyc[1] > log_rsp_cyc[0], 1'b1);
         chk("fence_load_after_atomic", log_iss_cyc[2] > log_rsp_cyc[1], 1'b1);
      end

      // unexpected response sets a sticky flag and is not forwarded
      do_reset();
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'h1234_5678;
      @(negedge clk);
      chk("unexp_no_rvalid", lsu_rvalid_o, 1'b0);
      chk("unexp_not_yet", protocol_err_o, 1'b0);
      tick();
      idle_inputs();
      @(negedge clk);
      chk("unexp_set", protocol_err_o, 1'b1);
      chk("unexp_busy", busy_o, 1'b0);
      tick();
      lq.push_back('{addr: 32'h400, we: 1'b0, be: 4'hF, wdata: 32'h0, atop: 6'h0});
      run_engine(20, 0, 100, 2, 2, 0);
      @(negedge clk);
      chk("unexp_sticky", protocol_err_o, 1'b1);
      tick();
      do_reset();
      @(negedge clk);
      chk("unexp_cleared", protocol_err_o, 1'b0);
      tick();

      // reset with two requests queued
      drive_lsu(1'b1, '{addr: 32'h500, we: 1'b0, be: 4'hF, wdata: 32'h0, atop: 6'h0});
      @(negedge clk);
      chk("mid_gnt0", lsu_gnt_o, 1'b1);
      tick();
      drive_lsu(1'b1, '{addr: 32'h504, we: 1'b0, be: 4'hF, wdata: 32'h0, atop: 6'h0});
      @(negedge clk);
      chk("mid_gnt1", lsu_gnt_o, 1'b1);
      chk("mid_req", mem_req_o, 1'b1);
      tick();
      drive_lsu(1'b0, '0);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      @(negedge clk);
      chk("mid_rst_mem_req", mem_req_o, 1'b0);
      chk("mid_rst_busy", busy_o, 1'b0);
      chk("mid_rst_gnt", lsu_gnt_o, 1'b0);
      tick();
      drive_lsu(1'b1, '{addr: 32'h508, we: 1'b0, be: 4'hF, wdata: 32'h0, atop: 6'h0});
      mem_rvalid_i = 1'b1;
      @(negedge clk);
      chk("mid_gnt_follows", lsu_gnt_o, 1'b1);
      chk("mid_late_rvalid", lsu_rvalid_o, 1'b0);
      tick();
      idle_inputs();
      @(negedge clk);
      chk("mid_protocol_err", protocol_err_o, 1'b1);
      chk("mid_new_req_addr", mem_addr_o, 32'h508);
      tick();

      // randomized traffic against the model
      for (int pass = 0; pass < 2; pass++) begin
         do_reset();
         for (int i = 0; i < 150; i++) begin
            data_req_t r;
            r.addr  = $urandom() & 32'hFFFF_FFFC;
            r.we    = 1'($urandom_range(0, 1));
            r.be    = 4'($urandom_range(0, 15));
            r.wdata = $urandom();
            r.atop  = ($urandom_range(0, 4) == 0) ? 6'($urandom_range(1, 63)) : 6'h00;
            lq.push_back(r);
         end
         if (pass == 0) run_engine(6000, 0, 60, 1, 4, 25);
         else run_engine(6000, 0, 100, 1, 1, 10);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
